column_pingpong_buffer: RTL

Double-buffered column store between `frame_manager` and `hub75_output`. `frame_manager` streams one column of `NUM_ROWS` pixels into the write bank. `hub75_output` reads the other bank as top-half/bottom-half pixel pairs by scan address. Banks swap only on a `hub75_output` swap request and only when the write bank is complete, so the panel never shows a half-written column.

---
 rtl/column_pingpong_buffer_pkg.sv | 11 +
 rtl/display_pkg.sv | 10 +
 rtl/column_pingpong_buffer_if.sv | 32 +++
 rtl/column_bank_ram.sv | 33 +++
 rtl/column_pingpong_buffer.sv | 128 ++++++++++++
 5 files changed

// File: rtl/column_pingpong_buffer_pkg.sv
// Types local to the column ping-pong buffer.
package column_pingpong_buffer_pkg;

  localparam int UNDERRUN_W_DEFAULT = 16;

  typedef enum logic [0:0] {
    ST_FILLING = 1'b0,
    ST_FULL    = 1'b1
  } wr_state_e;

endpackage

// File: rtl/display_pkg.sv
// Display geometry shared by frame_manager, column_pingpong_buffer and hub75_output.
package display_pkg;

  localparam int NUM_ROWS  = 64;
  localparam int SCAN_RATE = 32;
  localparam int RGB_RES   = 9;

  typedef logic [RGB_RES-1:0] pixel_t;

endpackage

// File: rtl/column_pingpong_buffer_if.sv
// Write stream, swap handshake and scan-read bundle of the column ping-pong buffer.
interface column_pingpong_buffer_if
  import column_pingpong_buffer_pkg::*;
#(
  parameter int RGB_RES    = display_pkg::RGB_RES,
  parameter int SCAN_RATE  = display_pkg::SCAN_RATE,
  parameter int UNDERRUN_W = UNDERRUN_W_DEFAULT
);

  logic                         wr_valid;
  logic                         wr_ready;
  logic                         wr_first;
  logic [RGB_RES-1:0]           wr_data;
  logic                         swap_req;
  logic                         swap_ack;
  logic                         swap_stale;
  logic [$clog2(SCAN_RATE)-1:0] rd_addr;
  logic [RGB_RES-1:0]           rd_data0;
  logic [RGB_RES-1:0]           rd_data1;
  logic [UNDERRUN_W-1:0]        underrun_count;

  modport master (
    output wr_valid, wr_first, wr_data, swap_req, rd_addr,
    input  wr_ready, swap_ack, swap_stale, rd_data0, rd_data1, underrun_count
  );

  modport slave (
    input  wr_valid, wr_first, wr_data, swap_req, rd_addr,
    output wr_ready, swap_ack, swap_stale, rd_data0, rd_data1, underrun_count
  );

endinterface

// File: rtl/column_bank_ram.sv
// Two-bank column RAM: one write port, two registered read ports, no reset so it maps to distributed RAM.
module column_bank_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 9
) (
  input  logic                     clk_in,
  input  logic                     wr_en_i,
  input  logic                     wr_bank_i,
  input  logic [$clog2(DEPTH)-1:0] wr_row_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_bank_i,
  input  logic [$clog2(DEPTH)-1:0] rd_row0_i,
  input  logic [$clog2(DEPTH)-1:0] rd_row1_i,
  output logic [WIDTH-1:0]         rd_data0_o,
  output logic [WIDTH-1:0]         rd_data1_o
);

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [WIDTH-1:0] rd_data0_q;
  logic [WIDTH-1:0] rd_data1_q;

  always_ff @(posedge clk_in) begin
    if (wr_en_i) begin
      mem_q[wr_bank_i][wr_row_i] <= wr_data_i;
    end
    rd_data0_q <= mem_q[rd_bank_i][rd_row0_i];
    rd_data1_q <= mem_q[rd_bank_i][rd_row1_i];
  end

  assign rd_data0_o = rd_data0_q;
  assign rd_data1_o = rd_data1_q;

endmodule

// File: rtl/column_pingpong_buffer.sv
// Double-buffered column store: frame_manager fills one bank while hub75_output scans the other.
//
// state      | meaning
// ST_FILLING | write bank accepting beats, wr_ready=1
// ST_FULL    | write bank holds a complete column, waiting for a swap request
module column_pingpong_buffer
  import column_pingpong_buffer_pkg::*;
#(
  parameter int NUM_ROWS   = display_pkg::NUM_ROWS,
  parameter int SCAN_RATE  = display_pkg::SCAN_RATE,
  parameter int RGB_RES    = display_pkg::RGB_RES,
  parameter int UNDERRUN_W = UNDERRUN_W_DEFAULT
) (
  input logic                    clk_in,
  input logic                    rst_in,
  column_pingpong_buffer_if.slave bus
);

  localparam int ROW_W = $clog2(NUM_ROWS);

  if (NUM_ROWS != 2 * SCAN_RATE) begin : g_bad_geometry
    $error("column_pingpong_buffer: NUM_ROWS must equal 2*SCAN_RATE");
  end

  wr_state_e             state_q, state_d;
  logic [ROW_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ROW_W-1:0]      wr_row;
  logic                  rd_bank_q, rd_bank_d;
  logic                  rd_bank_valid_q, rd_bank_valid_d;
  logic                  rd_mask_q;
  logic                  swap_ack_q, swap_ack_d;
  logic                  swap_stale_q, swap_stale_d;
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
  logic                  wr_ready;
  logic                  wr_fire;
  logic [RGB_RES-1:0]    ram_rd0;
  logic [RGB_RES-1:0]    ram_rd1;

  assign wr_ready = rst_in && (state_q == ST_FILLING);
  assign wr_fire  = bus.wr_valid && wr_ready;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q         <= ST_FILLING;
      wr_ptr_q        <= '0;
      rd_bank_q       <= 1'b0;
      rd_bank_valid_q <= 1'b0;
      rd_mask_q       <= 1'b0;
      swap_ack_q      <= 1'b0;
      swap_stale_q    <= 1'b0;
      underrun_q      <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_bank_q       <= rd_bank_d;
      rd_bank_valid_q <= rd_bank_valid_d;
      rd_mask_q       <= rd_bank_valid_q;
      swap_ack_q      <= swap_ack_d;
      swap_stale_q    <= swap_stale_d;
      underrun_q      <= underrun_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_bank_d       = rd_bank_q;
    rd_bank_valid_d = rd_bank_valid_q;
    swap_ack_d      = 1'b0;
    swap_stale_d    = 1'b0;
    underrun_d      = underrun_q;
    wr_row          = bus.wr_first ? '0 : wr_ptr_q;

    case (state_q)
      ST_FILLING: begin
        if (wr_fire) begin
          wr_ptr_d = wr_row + 1'b1;
          if (wr_row == ROW_W'(NUM_ROWS - 1)) begin
            state_d  = ST_FULL;
            wr_ptr_d = '0;
          end
        end
      end
      default: ;
    endcase

    // Swap decision uses the state at the start of the cycle, so a final beat
    // arriving together with the request still counts as an underrun.
    if (bus.swap_req) begin
      swap_ack_d = 1'b1;
      if (state_q == ST_FULL) begin
        state_d         = ST_FILLING;
        wr_ptr_d        = '0;
        rd_bank_d       = ~rd_bank_q;
        rd_bank_valid_d = 1'b1;
      end else begin
        swap_stale_d = 1'b1;
        if (underrun_q != '1) begin
          underrun_d = underrun_q + 1'b1;
        end
      end
    end
  end

  column_bank_ram #(
    .DEPTH(NUM_ROWS),
    .WIDTH(RGB_RES)
  ) u_ram (
    .clk_in     (clk_in),
    .wr_en_i    (wr_fire),
    .wr_bank_i  (~rd_bank_q),
    .wr_row_i   (wr_row),
    .wr_data_i  (bus.wr_data),
    .rd_bank_i  (rd_bank_q),
    .rd_row0_i  (ROW_W'(bus.rd_addr)),
    .rd_row1_i  (ROW_W'(bus.rd_addr) + ROW_W'(SCAN_RATE)),
    .rd_data0_o (ram_rd0),
    .rd_data1_o (ram_rd1)
  );

  assign bus.wr_ready       = wr_ready;
  assign bus.swap_ack       = swap_ack_q;
  assign bus.swap_stale     = swap_stale_q;
  assign bus.underrun_count = underrun_q;
  assign bus.rd_data0       = rd_mask_q ? ram_rd0 : '0;
  assign bus.rd_data1       = rd_mask_q ? ram_rd1 : '0;

endmodule
